wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 139 +++++++++++++
 tb/tb_wb_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Register-file write-back arbiter. A single-cycle ALU result that cannot be
// stalled always wins. Long-latency (load/div) results go into a small
// in-order FIFO and drain whenever the ALU leaves the write port free. When
// the FIFO is empty, a long-latency result can be written straight through.
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   alu_valid/wreg/wdata ALU result (wreg 0 = no write)
//   alu_link, alu_pc     jal/jalr link write: r31 <= alu_pc + 8
//   mem_valid/wreg/wdata long-latency result, accepted when mem_ready
//   mem_ready            FIFO has room (depends on current fill level only)
//   RegWrite/wreg/wdata  registered register-file write port
//   busy_mask            one bit per register with a queued pending write
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_wreg,
    input  logic [31:0] alu_wdata,
    input  logic        alu_link,
    input  logic [31:0] alu_pc,
    input  logic        mem_valid,
    input  logic [4:0]  mem_wreg,
    input  logic [31:0] mem_wdata,
    output logic        mem_ready,
    output logic        RegWrite,
    output logic [4:0]  wreg,
    output logic [31:0] wdata,
    output logic [31:0] busy_mask
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [4:0]       r_fifo_wreg  [DEPTH];
    logic [31:0]      r_fifo_wdata [DEPTH];
    logic [DEPTH-1:0] r_fifo_vld;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             r_we;
    logic [4:0]       r_wreg;
    logic [31:0]      r_wdata;

    logic [4:0]       w_alu_dst;
    logic [31:0]      w_alu_dat;
    logic             w_alu_sel;
    logic             w_empty;
    logic             w_ready;
    logic             w_mem_keep;
    logic             w_pop;
    logic             w_direct;
    logic             w_push;
    logic [31:0]      w_busy;

    assign w_alu_dst = alu_link ? 5'd31 : alu_wreg;
    assign w_alu_dat = alu_link ? (alu_pc + 32'd8) : alu_wdata;
    assign w_alu_sel = alu_valid && (w_alu_dst != 5'd0);

    assign w_empty   = (r_count == '0);
    // No same-cycle pop credit: a full FIFO refuses even while it drains.
    assign w_ready   = (r_count < CW'(DEPTH)) && !rst;

    // Accepted results to r0 are consumed here and never reach the FIFO.
    assign w_mem_keep = mem_valid && w_ready && (mem_wreg != 5'd0);
    assign w_pop      = !w_alu_sel && !w_empty;
    // Bypass only with an empty FIFO so nothing overtakes an older entry.
    assign w_direct   = !w_alu_sel && w_empty && w_mem_keep;
    assign w_push     = w_mem_keep && !w_direct;

    always_comb begin
        w_busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_fifo_vld[i]) begin
                w_busy[r_fifo_wreg[i]] = 1'b1;
            end
        end
        w_busy[0] = 1'b0;
        if (rst) begin
            w_busy = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_wreg     <= '0;
            r_wdata    <= '0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_fifo_vld <= '0;
        end else begin
            r_we <= w_alu_sel || w_pop || w_direct;

            if (w_alu_sel) begin
                r_wreg  <= w_alu_dst;
                r_wdata <= w_alu_dat;
            end else if (w_pop) begin
                r_wreg  <= r_fifo_wreg[r_rd_ptr];
                r_wdata <= r_fifo_wdata[r_rd_ptr];
            end else if (w_direct) begin
                r_wreg  <= mem_wreg;
                r_wdata <= mem_wdata;
            end

            if (w_pop) begin
                r_fifo_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr             <= r_rd_ptr + PW'(1);
            end

            // Push can never land on the slot being popped: that would need
            // a full FIFO, and a full FIFO does not accept.
            if (w_push) begin
                r_fifo_wreg[r_wr_ptr]  <= mem_wreg;
                r_fifo_wdata[r_wr_ptr] <= mem_wdata;
                r_fifo_vld[r_wr_ptr]   <= 1'b1;
                r_wr_ptr               <= r_wr_ptr + PW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign mem_ready = w_ready;
    assign RegWrite  = r_we;
    assign wreg      = r_wreg;
    assign wdata     = r_wdata;
    assign busy_mask = w_busy;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_wreg;
    logic [31:0] alu_wdata;
    logic        alu_link;
    logic [31:0] alu_pc;
    logic        mem_valid;
    logic [4:0]  mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        RegWrite;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [31:0] busy_mask;

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_wreg  (alu_wreg),
        .alu_wdata (alu_wdata),
        .alu_link  (alu_link),
        .alu_pc    (alu_pc),
        .mem_valid (mem_valid),
        .mem_wreg  (mem_wreg),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .RegWrite  (RegWrite),
        .wreg      (wreg),
        .wdata     (wdata),
        .busy_mask (busy_mask)
    );

    // Reference model: pending long-latency results as an ordered list.
    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic        m_known = 1'b0;
    logic        m_we;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        av;
        logic        al;
        logic [4:0]  awreg;
        logic [31:0] awdata;
        logic [31:0] apc;
        logic        mv;
        logic [4:0]  mwreg;
        logic [31:0] mwdata;
        logic        ewe;
        logic [4:0]  ewreg;
        logic [31:0] ewdata;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] m;
        m = '0;
        foreach (q[i]) m[q[i].r] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic idle();
        rst       = 1'b0;
        alu_valid = 1'b0;
        alu_link  = 1'b0;
        alu_wreg  = '0;
        alu_wdata = '0;
        alu_pc    = '0;
        mem_valid = 1'b0;
        mem_wreg  = '0;
        mem_wdata = '0;
    endtask

    // One clock: compare everything against the model, advance the model,
    // return 1 time unit after the rising edge.
    task automatic tick();
        logic        rdy;
        logic [4:0]  adst;
        logic [31:0] adat;
        ent_t        e;
        @(negedge clk);
        rdy = !rst && (q.size() < DEPTH);
        if (m_known) begin
            chk("model_RegWrite", 32'(RegWrite), 32'(m_we));
            chk("model_wreg", 32'(wreg), 32'(m_wreg));
            chk("model_wdata", wdata, m_wdata);
        end
        chk("model_mem_ready", 32'(mem_ready), 32'(rdy));
        chk("model_busy_mask", busy_mask, rst ? 32'd0 : model_busy());
        if (rst) begin
            q.delete();
            m_we    = 1'b0;
            m_wreg  = '0;
            m_wdata = '0;
            m_known = 1'b1;
        end else begin
            adst = alu_link ? 5'd31 : alu_wreg;
            adat = alu_link ? alu_pc + 32'd8 : alu_wdata;
            // Accepted result joins the back of the line; the write port then
            // serves the ALU, else the oldest pending result.
            if (mem_valid && rdy && mem_wreg != 5'd0) q.push_back('{mem_wreg, mem_wdata});
            if (alu_valid && adst != 5'd0) begin
                m_we = 1'b1; m_wreg = adst; m_wdata = adat;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                m_we = 1'b1; m_wreg = e.r; m_wdata = e.d;
            end else begin
                m_we = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1, 1, 5'd4, 32'h0BAD0BAD, 32'h00400010, 0, 5'd0, 32'h0, 1, 5'd31, 32'h00400018};
        vecs[1] = '{0, 0, 5'd0, 32'h0, 32'h0, 1, 5'd5, 32'hDEADBEEF, 1, 5'd5, 32'hDEADBEEF};
        vecs[2] = '{1, 0, 5'd0, 32'h11111111, 32'h0, 1, 5'd3, 32'h00000033, 1, 5'd3, 32'h00000033};
        vecs[3] = '{1, 0, 5'd7, 32'h12345678, 32'h0, 0, 5'd0, 32'h0, 1, 5'd7, 32'h12345678};
        vecs[4] = '{1, 0, 5'd0, 32'hAAAAAAAA, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0};
        vecs[5] = '{0, 0, 5'd0, 32'h0, 32'h0, 1, 5'd0, 32'h55555555, 0, 5'd0, 32'h0};
        vecs[6] = '{1, 1, 5'd0, 32'h0, 32'hFFFFFFFC, 0, 5'd0, 32'h0, 1, 5'd31, 32'h00000004};
        vecs[7] = '{0, 1, 5'd2, 32'h0, 32'h00001000, 1, 5'd9, 32'h000000A5, 1, 5'd9, 32'h000000A5};

        idle();
        rst = 1'b1;
        #1;
        chk("reset_mem_ready", 32'(mem_ready), 32'd0);
        chk("reset_busy", busy_mask, 32'd0);
        tick();
        tick();
        chk("reset_RegWrite", 32'(RegWrite), 32'd0);
        chk("reset_wreg", 32'(wreg), 32'd0);
        chk("reset_wdata", wdata, 32'd0);
        idle();
        #1;
        chk("post_reset_mem_ready", 32'(mem_ready), 32'd1);

        // Single-cycle vectors from an empty FIFO.
        for (int i = 0; i < 8; i++) begin
            idle();
            alu_valid = vecs[i].av;    alu_link  = vecs[i].al;
            alu_wreg  = vecs[i].awreg; alu_wdata = vecs[i].awdata;
            alu_pc    = vecs[i].apc;
            mem_valid = vecs[i].mv;    mem_wreg  = vecs[i].mwreg;
            mem_wdata = vecs[i].mwdata;
            tick();
            chk($sformatf("vec%0d_RegWrite", i), 32'(RegWrite), 32'(vecs[i].ewe));
            if (vecs[i].ewe) begin
                chk($sformatf("vec%0d_wreg", i), 32'(wreg), 32'(vecs[i].ewreg));
                chk($sformatf("vec%0d_wdata", i), wdata, vecs[i].ewdata);
            end
            chk($sformatf("vec%0d_busy", i), busy_mask, 32'd0);
            idle();
            tick();
            chk($sformatf("vec%0d_idle_RegWrite", i), 32'(RegWrite), 32'd0);
        end

        // ALU busy six cycles with mem offered each cycle: FIFO fills to 4.
        for (int k = 0; k < 6; k++) begin
            int mi;
            mi = (k < 4) ? k : 4;
            idle();
            alu_valid = 1'b1; alu_wreg = 5'(k + 1); alu_wdata = 32'h100 + k;
            mem_valid = 1'b1; mem_wreg = 5'(10 + mi); mem_wdata = 32'h2000 + 10 + mi;
            #1;
            chk($sformatf("fill_ready_k%0d", k), 32'(mem_ready), (k < 4) ? 32'd1 : 32'd0);
            tick();
            chk($sformatf("fill_wreg_k%0d", k), 32'(wreg), 32'(k + 1));
            chk($sformatf("fill_wdata_k%0d", k), wdata, 32'h100 + k);
        end
        chk("fill_busy", busy_mask, 32'h00003C00);
        chk("fill_ready_full", 32'(mem_ready), 32'd0);
        idle();
        for (int j = 0; j < 4; j++) begin
            tick();
            chk($sformatf("drain_RegWrite_%0d", j), 32'(RegWrite), 32'd1);
            chk($sformatf("drain_wreg_%0d", j), 32'(wreg), 32'(10 + j));
            chk($sformatf("drain_wdata_%0d", j), wdata, 32'h2000 + 10 + j);
        end
        chk("drain_busy", busy_mask, 32'd0);
        chk("drain_ready", 32'(mem_ready), 32'd1);
        tick();
        chk("drain_done", 32'(RegWrite), 32'd0);

        // Reset with three queued entries and live inputs.
        for (int k = 0; k < 3; k++) begin
            idle();
            alu_valid = 1'b1; alu_wreg = 5'(k + 1); alu_wdata = 32'h300 + k;
            mem_valid = 1'b1; mem_wreg = 5'(20 + k); mem_wdata = 32'h4000 + k;
            tick();
        end
        chk("rst_pre_busy", busy_mask, 32'h00700000);
        idle();
        rst = 1'b1;
        alu_valid = 1'b1; alu_wreg = 5'd4; alu_wdata = 32'hBADBAD00;
        mem_valid = 1'b1; mem_wreg = 5'd23; mem_wdata = 32'hBADBAD01;
        #1;
        chk("rst_mid_ready", 32'(mem_ready), 32'd0);
        chk("rst_mid_busy", busy_mask, 32'd0);
        tick();
        chk("rst_mid_RegWrite", 32'(RegWrite), 32'd0);
        chk("rst_mid_wreg", 32'(wreg), 32'd0);
        chk("rst_mid_wdata", wdata, 32'd0);
        idle();
        #1;
        chk("rst_after_ready", 32'(mem_ready), 32'd1);
        chk("rst_after_busy", busy_mask, 32'd0);
        for (int j = 0; j < 4; j++) begin
            tick();
            chk($sformatf("rst_no_stale_%0d", j), 32'(RegWrite), 32'd0);
        end

        // Three entries, then push+pop each cycle across the pointer wrap.
        for (int k = 0; k < 3; k++) begin
            idle();
            alu_valid = 1'b1; alu_wreg = 5'(k + 1); alu_wdata = 32'h500 + k;
            mem_valid = 1'b1; mem_wreg = 5'(20 + k); mem_wdata = 32'h6000 + 20 + k;
            tick();
        end
        for (int j = 0; j < 4; j++) begin
            idle();
            mem_valid = 1'b1; mem_wreg = 5'(23 + j); mem_wdata = 32'h6000 + 23 + j;
            #1;
            chk($sformatf("wrap_ready_%0d", j), 32'(mem_ready), 32'd1);
            tick();
            chk($sformatf("wrap_wreg_%0d", j), 32'(wreg), 32'(20 + j));
            chk($sformatf("wrap_wdata_%0d", j), wdata, 32'h6000 + 20 + j);
            chk($sformatf("wrap_busy_%0d", j), busy_mask, 32'h7 << (21 + j));
        end
        idle();
        for (int j = 0; j < 3; j++) begin
            tick();
            chk($sformatf("wrap_drain_%0d", j), 32'(wreg), 32'(24 + j));
        end
        tick();
        chk("wrap_done", 32'(RegWrite), 32'd0);

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 59) == 0);
            alu_valid = ($urandom_range(0, 1) == 1);
            alu_link  = ($urandom_range(0, 4) == 0);
            alu_wreg  = 5'($urandom_range(0, 7));
            alu_wdata = $urandom;
            alu_pc    = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFF8 : $urandom;
            mem_valid = ($urandom_range(0, 9) < 6);
            mem_wreg  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            mem_wdata = $urandom;
            tick();
        end
        idle();
        for (int j = 0; j < DEPTH + 2; j++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
